scanline_irq_ctrl: RTL and testbench

- Parametrised successor to the single-source 16V/32V IRQ logic in the Missile Command CPU wrapper.
- Generates 6502 IRQs from up to NUM_CH programmable scanline compares, with per-channel pending and acknowledge, priority encoding, and phi0/SYNC-aligned IRQ sampling.
- Adds the frame watchdog left open in the current CPU wrapper.
- Sits between the video counters and the 6502 core, inside the CPU subsystem.

---
 rtl/scanline_irq_pkg.sv | 9 +
 rtl/scanline_wdog.sv | 62 ++++++
 rtl/scanline_irq_ctrl.sv | 94 +++++++++
 tb/tb_scanline_irq_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/scanline_irq_pkg.sv
// Shared types and defaults for the scanline IRQ controller and its watchdog.
package scanline_irq_pkg;
    typedef enum logic {RUN, FIRE} wdog_state_t;

    localparam int IRQ_SRC_W       = 3;
    localparam int DEF_VOFFSET     = 10;
    localparam int DEF_WDOG_FRAMES = 8;
    localparam int DEF_WDOG_PULSE  = 16;
endpackage

// File: rtl/scanline_wdog.sv
// Frame watchdog: counts unpaused frames since the last kick and emits a
// fixed-length reset pulse when the frame budget runs out.
module scanline_wdog
    import scanline_irq_pkg::*;
#(
    parameter int WDOG_FRAMES = DEF_WDOG_FRAMES,
    parameter int WDOG_PULSE  = DEF_WDOG_PULSE
) (
    input  logic clk_10M,
    input  logic reset,
    input  logic frame_ev,
    input  logic pause,
    input  logic wdog_kick,
    output logic wdog_reset
);
    localparam int CNT_W   = 8;
    localparam int PULSE_W = $clog2(WDOG_PULSE + 1);

    wdog_state_t        state;
    logic [CNT_W-1:0]   cnt;
    logic [PULSE_W-1:0] pulse;
    logic               kick_q;

    always_ff @(posedge clk_10M) begin
        if (reset) begin
            state      <= RUN;
            cnt        <= '0;
            pulse      <= '0;
            wdog_reset <= 1'b0;
            kick_q     <= 1'b1;
        end else begin
            kick_q <= wdog_kick;
            case (state)
                RUN: begin
                    // A kick edge beats a coinciding frame increment
                    if (wdog_kick && !kick_q) begin
                        cnt <= '0;
                    end else if (frame_ev && !pause) begin
                        if (cnt == CNT_W'(WDOG_FRAMES - 1)) begin
                            state      <= FIRE;
                            wdog_reset <= 1'b1;
                            pulse      <= '0;
                            cnt        <= CNT_W'(WDOG_FRAMES);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FIRE: begin
                    if (pulse == PULSE_W'(WDOG_PULSE - 1)) begin
                        state      <= RUN;
                        wdog_reset <= 1'b0;
                        cnt        <= '0;
                    end else begin
                        pulse <= pulse + 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: rtl/scanline_irq_ctrl.sv
// Multi-channel scanline IRQ generator for the 6502 with per-channel pending/ack.
// Build with SCANLINE_IRQ_WDOG_EN defined to include the frame watchdog.
module scanline_irq_ctrl
    import scanline_irq_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int VCNT_W      = 8,
    parameter int VOFFSET     = DEF_VOFFSET,
    parameter int WDOG_FRAMES = DEF_WDOG_FRAMES,
    parameter int WDOG_PULSE  = DEF_WDOG_PULSE
) (
    input  logic                     clk_10M,
    input  logic                     reset,
    input  logic                     phi_0,
    input  logic                     sync,
    input  logic                     pause,
    input  logic [VCNT_W-1:0]        vcnt,
    input  logic                     intack_n,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [NUM_CH*VCNT_W-1:0] ch_line,
    input  logic                     wdog_kick,
    output logic                     irq_n,
    output logic [IRQ_SRC_W-1:0]     irq_src,
    output logic [NUM_CH-1:0]        pending,
    output logic                     wdog_reset
);
    logic [VCNT_W-1:0] vcnt_q;
    logic [VCNT_W-1:0] vadj;
    logic              line_ev;
    logic              intack_q;
    logic              sp_q;
    logic              ack_ev;
    logic              sp_rise;
    logic [NUM_CH-1:0] set_vec;
    logic [NUM_CH-1:0] clr_vec;

    assign vadj    = vcnt - VCNT_W'(VOFFSET);
    assign line_ev = (vcnt != vcnt_q);
    assign ack_ev  = intack_q && !intack_n;
    assign sp_rise = sync && phi_0 && !sp_q;

    always_comb begin
        set_vec = '0;
        for (int i = 0; i < NUM_CH; i++)
            set_vec[i] = line_ev && ch_en[i] && (ch_line[i*VCNT_W +: VCNT_W] == vadj);
    end

    // Lowest pending index wins; downward scan leaves the lowest one last
    always_comb begin
        irq_src = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (pending[i]) irq_src = IRQ_SRC_W'(i);
    end

    assign clr_vec = ack_ev ? ((NUM_CH'(1) << irq_src) & pending) : '0;

    always_ff @(posedge clk_10M) begin
        if (reset) begin
            vcnt_q   <= vcnt;
            intack_q <= 1'b1;
            sp_q     <= 1'b1;
            pending  <= '0;
            irq_n    <= 1'b1;
        end else begin
            vcnt_q   <= vcnt;
            intack_q <= intack_n;
            sp_q     <= sync && phi_0;
            pending  <= (pending & ~clr_vec) | set_vec;
            if (sp_rise)
                irq_n <= ~|pending;
        end
    end

`ifdef SCANLINE_IRQ_WDOG_EN
    logic frame_ev;
    assign frame_ev = line_ev && (vadj == '0);

    scanline_wdog #(
        .WDOG_FRAMES(WDOG_FRAMES),
        .WDOG_PULSE (WDOG_PULSE)
    ) u_wdog (
        .clk_10M   (clk_10M),
        .reset     (reset),
        .frame_ev  (frame_ev),
        .pause     (pause),
        .wdog_kick (wdog_kick),
        .wdog_reset(wdog_reset)
    );
`else
    logic unused_wdog;
    assign unused_wdog = &{1'b0, pause, wdog_kick};
    assign wdog_reset  = 1'b0;
`endif
endmodule

// File: tb/tb_scanline_irq_ctrl.sv
// Randomised and directed bench for scanline_irq_ctrl against a cycle-level
// behavioural model; watchdog checks follow SCANLINE_IRQ_WDOG_EN.
module tb_scanline_irq_ctrl;
    localparam int NUM_CH      = 4;
    localparam int VCNT_W      = 8;
    localparam int VOFFSET     = 10;
    localparam int WDOG_FRAMES = 8;
    localparam int WDOG_PULSE  = 16;

    logic                     clk_10M = 1'b0;
    logic                     reset;
    logic                     phi_0, sync, pause, intack_n, wdog_kick;
    logic [VCNT_W-1:0]        vcnt;
    logic [NUM_CH-1:0]        ch_en;
    logic [NUM_CH*VCNT_W-1:0] ch_line;
    logic                     irq_n, wdog_reset;
    logic [2:0]               irq_src;
    logic [NUM_CH-1:0]        pending;

    int compared   = 0;
    int mismatched = 0;
    bit chk_on     = 1'b0;

    scanline_irq_ctrl #(
        .NUM_CH(NUM_CH), .VCNT_W(VCNT_W), .VOFFSET(VOFFSET),
        .WDOG_FRAMES(WDOG_FRAMES), .WDOG_PULSE(WDOG_PULSE)
    ) dut (
        .clk_10M(clk_10M), .reset(reset), .phi_0(phi_0), .sync(sync), .pause(pause),
        .vcnt(vcnt), .intack_n(intack_n), .ch_en(ch_en), .ch_line(ch_line),
        .wdog_kick(wdog_kick), .irq_n(irq_n), .irq_src(irq_src), .pending(pending),
        .wdog_reset(wdog_reset)
    );

    always #50 clk_10M = ~clk_10M;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [NUM_CH-1:0] m_pend, m_old;
    logic              m_irq_n;
    logic [VCNT_W-1:0] m_prev_vcnt, m_vadj;
    bit                m_prev_ack, m_prev_sp, m_prev_kick;
    int                m_frames, m_fire_left;

    function automatic int lowest(input logic [NUM_CH-1:0] p);
        for (int i = 0; i < NUM_CH; i++)
            if (p[i]) return i;
        return 0;
    endfunction

    always @(posedge clk_10M) begin
        if (reset) begin
            m_pend = '0; m_irq_n = 1'b1; m_prev_vcnt = vcnt;
            m_prev_ack = 1'b1; m_prev_sp = 1'b1; m_prev_kick = 1'b1;
            m_frames = 0; m_fire_left = 0;
        end else begin
            m_vadj = (vcnt + 8'd256 - 8'(VOFFSET)) % 256;
            m_old  = m_pend;
            if (!m_prev_sp && sync && phi_0) m_irq_n = (m_old == 0);
            if (m_prev_ack && !intack_n && m_old != 0) m_pend[lowest(m_old)] = 1'b0;
            if (vcnt != m_prev_vcnt)
                for (int i = 0; i < NUM_CH; i++)
                    if (ch_en[i] && ch_line[i*VCNT_W +: VCNT_W] == m_vadj) m_pend[i] = 1'b1;
            if (m_fire_left > 0) begin
                m_fire_left--;
                if (m_fire_left == 0) m_frames = 0;
            end else if (wdog_kick && !m_prev_kick) begin
                m_frames = 0;
            end else if (vcnt != m_prev_vcnt && m_vadj == 0 && !pause) begin
                m_frames++;
                if (m_frames == WDOG_FRAMES) m_fire_left = WDOG_PULSE;
            end
            m_prev_vcnt = vcnt; m_prev_ack = intack_n;
            m_prev_sp = sync && phi_0; m_prev_kick = wdog_kick;
        end
    end

    always @(posedge clk_10M) begin
        #1;
        if (chk_on) begin
            check("pending", 32'(pending), 32'(m_pend));
            check("irq_src", 32'(irq_src), 32'(lowest(m_pend)));
            check("irq_n", 32'(irq_n), 32'(m_irq_n));
`ifdef SCANLINE_IRQ_WDOG_EN
            check("wdog_reset", 32'(wdog_reset), 32'(m_fire_left > 0));
`else
            check("wdog_reset_tied", 32'(wdog_reset), 32'd0);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk_10M);
    endtask

    task automatic fetch();
        sync = 1'b1; phi_0 = 1'b1; cyc();
        sync = 1'b0; phi_0 = 1'b0; cyc();
    endtask

    task automatic ack();
        intack_n = 1'b0; cyc();
        intack_n = 1'b1; cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1; cyc(2);
        reset = 1'b0; cyc();
    endtask

    task automatic frame();
        vcnt = 8'(VOFFSET + 1); cyc();
        vcnt = 8'(VOFFSET);     cyc();
    endtask

    initial begin
        int hi;
        reset = 1'b1; phi_0 = 0; sync = 0; pause = 0; intack_n = 1; wdog_kick = 0;
        vcnt = '0; ch_en = '0; ch_line = '0;
        cyc(2);
        chk_on = 1'b1;
        check("rst_pending", 32'(pending), 0);
        check("rst_irq_n", 32'(irq_n), 1);
        check("rst_irq_src", 32'(irq_src), 0);
        check("rst_wdog", 32'(wdog_reset), 0);
        reset = 1'b0; cyc();

        // Sweep: pending[0] sets when vcnt steps onto 0x1A
        ch_en = 4'b0001; ch_line[7:0] = 8'h10;
        for (int v = 0; v < 8'h1A; v++) begin vcnt = 8'(v); cyc(); end
        check("sweep_pre", 32'(pending), 0);
        vcnt = 8'h1A; cyc();
        check("sweep_set", 32'(pending), 1);
        check("sweep_irq_hold", 32'(irq_n), 1);
        fetch();
        check("sweep_irq_low", 32'(irq_n), 0);
        for (int v = 8'h1B; v < 256; v++) begin vcnt = 8'(v); cyc(); end
        ch_en = '0; ack(); fetch();
        check("sweep_irq_rel", 32'(irq_n), 1);

        // Priority with two simultaneous matches
        ch_line = {8'h40, 8'h20, 8'h20, 8'h10}; ch_en = 4'b1111;
        vcnt = 8'h29; cyc();
        vcnt = 8'h2A; cyc();
        check("prio_pend", 32'(pending), 32'b0110);
        check("prio_src", 32'(irq_src), 1);
        fetch();
        check("prio_irq", 32'(irq_n), 0);
        ack();
        check("ack1_pend", 32'(pending), 32'b0100);
        check("ack1_src", 32'(irq_src), 2);
        ack();
        check("ack2_pend", 32'(pending), 0);
        fetch();
        check("ack2_irq", 32'(irq_n), 1);

        // Set beats acknowledge on the same channel
        ch_en = 4'b0001;
        vcnt = 8'h19; cyc();
        vcnt = 8'h1A; cyc();
        vcnt = 8'h19; cyc();
        vcnt = 8'h1A; intack_n = 1'b0; cyc();
        intack_n = 1'b1;
        check("set_wins", 32'(pending), 1);
        ch_en = 4'b0000; cyc();
        check("disable_keeps", 32'(pending), 1);
        ack();
        check("set_wins_clr", 32'(pending), 0);

        // Wrap-around compare: vcnt 5 -> vadj 251
        ch_en = 4'b0001; ch_line[7:0] = 8'd251;
        vcnt = 8'd4; cyc();
        vcnt = 8'd5; cyc();
        check("wrap_set", 32'(pending), 1);
        ch_en = '0; ack();

`ifdef SCANLINE_IRQ_WDOG_EN
        do_reset();
        repeat (WDOG_FRAMES - 1) frame();
        check("wd_pre", 32'(wdog_reset), 0);
        frame();
        hi = 0;
        for (int i = 0; i < 40; i++) begin if (wdog_reset) hi++; cyc(); end
        check("wd_pulse_len", 32'(hi), 32'(WDOG_PULSE));

        do_reset();
        repeat (7) frame();
        wdog_kick = 1'b1; cyc(); wdog_kick = 1'b0; cyc();
        repeat (7) frame();
        check("wd_kick_nofire", 32'(wdog_reset), 0);
        frame();
        check("wd_kick_refire", 32'(wdog_reset), 1);
        cyc(3);
        reset = 1'b1; cyc();
        check("wd_rst_abort", 32'(wdog_reset), 0);
        reset = 1'b0; cyc();

        pause = 1'b1; hi = 0;
        for (int i = 0; i < 20; i++) begin frame(); if (wdog_reset) hi++; end
        pause = 1'b0;
        check("wd_pause", 32'(hi), 0);
        do_reset();
`endif

        // Randomised phase
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 65)      vcnt = vcnt + 1'b1;
            else if (r < 75) vcnt = vcnt;
            else if (r < 90) vcnt = (vcnt == 8'(VOFFSET)) ? 8'(VOFFSET + 1) : 8'(VOFFSET);
            else             vcnt = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 49) == 0) ch_en = 4'($urandom);
            if ($urandom_range(0, 99) == 0) ch_line = 32'($urandom);
            intack_n  = ($urandom_range(0, 4) != 0);
            sync      = ($urandom_range(0, 3) == 0);
            phi_0     = $urandom_range(0, 1) == 1;
            wdog_kick = ($urandom_range(0, 39) == 0);
            pause     = ($urandom_range(0, 9) == 0);
            reset     = ($urandom_range(0, 299) == 0);
            cyc();
        end
        reset = 1'b0; cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
